// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the MIPS multiply/divide unit: op codes, FSM state
//   type, divider iteration count and the divide-by-zero LO pattern.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIV   = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_MTHI  = 3'd4;
    localparam op_t OP_MTLO  = 3'd5;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIVZ_LO   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Codes 6 and 7 are unassigned and are never accepted.
    function automatic logic op_is_legal(input op_t op);
        return op <= OP_MTLO;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request / write-beat bundle between EX and the multiply/divide unit.
//   master : EX side (drives start/op/src_a/src_b/cancel, sees busy and beat)
//   slave  : muldiv_unit (drives busy, wen_hiol, data_out)
//   wen_hiol bit0 writes HI from data_out upper half, bit1 writes LO from the
//   lower half.
// -----------------------------------------------------------------------------
interface muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                  start;
    op_t                   op;
    logic [DATA_W-1:0]     src_a;
    logic [DATA_W-1:0]     src_b;
    logic                  cancel;
    logic                  busy;
    logic [1:0]            wen_hiol;
    logic [2*DATA_W-1:0]   data_out;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, wen_hiol, data_out
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, wen_hiol, data_out
    );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
//   Unsigned radix-2 restoring divider, one quotient bit per enabled cycle.
//   Ports:
//     clk, rst            clock, async active-high reset
//     load                capture dividend/divisor and arm DIV_ITERS steps
//     step_en             allow an iteration this cycle
//     kill                abandon the current division
//     dividend, divisor   unsigned operands (sampled on load)
//     quotient, remainder result, valid while done is high
//     done                all iterations finished, result stable
// -----------------------------------------------------------------------------
module div_core
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step_en,
    input  logic              kill,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);
    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic [DATA_W-1:0] rem_q,  rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              run_q,  run_d;

    logic [DATA_W-1:0] rem_sh;
    logic              fits;

    always_comb begin
        // Shift the next dividend bit into the partial remainder. The bit
        // shifted out of rem_q is the implicit MSB of the shifted value: when
        // it is set the shifted remainder is certainly >= divisor, and the
        // modulo-2^DATA_W subtraction still yields the correct result.
        rem_sh = {rem_q[DATA_W-2:0], quot_q[DATA_W-1]};
        fits   = rem_q[DATA_W-1] | (rem_sh >= dvsr_q);

        rem_d  = rem_q;
        quot_d = quot_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;

        if (kill) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (load) begin
            rem_d  = '0;
            quot_d = dividend;
            dvsr_d = divisor;
            cnt_d  = CNT_W'(DIV_ITERS);
            run_d  = 1'b1;
        end else if (step_en && run_q && (cnt_q != '0)) begin
            rem_d  = fits ? (rem_sh - dvsr_q) : rem_sh;
            quot_d = {quot_q[DATA_W-2:0], fits};
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = run_q && (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle MIPS multiply/divide engine; the only writer of HI/LO.
//   Ports:
//     clk            clock
//     rst            async active-high reset
//     bus (slave)    start/op/src_a/src_b/cancel in; busy, wen_hiol and the
//                    {HI,LO} write beat data_out out
//   Parameters:
//     DATA_W         operand width (data_out is 2*DATA_W)
//     MUL_PIPE       register stages after the multiplier array (0..3)
//   Latency from acceptance in cycle T: mul T+2+MUL_PIPE, div T+34,
//   MTHI/MTLO/divide-by-zero T+1. busy covers every cycle up to the beat.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_PIPE = 1
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    state_e                state_q,   state_d;
    logic                  busy_q,    busy_d;
    logic [1:0]            wen_q,     wen_d;
    logic [2*DATA_W-1:0]   data_q,    data_d;
    op_t                   op_q,      op_d;
    logic [DATA_W-1:0]     a_q,       a_d;
    logic [DATA_W-1:0]     b_q,       b_d;
    logic [1:0]            mul_cnt_q, mul_cnt_d;
    logic                  qneg_q,    qneg_d;
    logic                  rneg_q,    rneg_d;

    logic                  div_load;
    logic                  div_kill;
    logic                  div_done;
    logic                  div_signed;
    logic [DATA_W-1:0]     div_quot;
    logic [DATA_W-1:0]     div_rem;

    logic                     mul_signed;
    logic signed [DATA_W:0]   mul_a_ext;
    logic signed [DATA_W:0]   mul_b_ext;
    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [2*DATA_W-1:0] prod_p1_q;
    logic signed [2*DATA_W-1:0] prod_p2_q;
    logic signed [2*DATA_W-1:0] prod_p3_q;
    logic signed [2*DATA_W-1:0] prod_sel;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                     input logic neg);
        return neg ? -mag : mag;
    endfunction

    // ---- divider: works on magnitudes, signs restored at write-back ----
    assign div_signed = (bus.op == OP_DIV);

    div_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step_en   (state_q == ST_DIV),
        .kill      (div_kill),
        .dividend  (magnitude(bus.src_a, div_signed)),
        .divisor   (magnitude(bus.src_b, div_signed)),
        .quotient  (div_quot),
        .remainder (div_rem),
        .done      (div_done)
    );

    // ---- multiplier stage p0: 33-bit extended operands cover MULT and MULTU ----
    always_comb begin
        mul_signed = (op_q == OP_MULT);
        mul_a_ext  = {mul_signed & a_q[DATA_W-1], a_q};
        mul_b_ext  = {mul_signed & b_q[DATA_W-1], b_q};
        prod_p0    = (2*DATA_W)'(mul_a_ext) * (2*DATA_W)'(mul_b_ext);
    end

    // ---- multiplier stages p1..p3: operands stay put while in MUL ----
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p0;
        prod_p2_q <= prod_p1_q;
        prod_p3_q <= prod_p2_q;
    end

    always_comb begin
        case (MUL_PIPE)
            0:       prod_sel = prod_p0;
            1:       prod_sel = prod_p1_q;
            2:       prod_sel = prod_p2_q;
            default: prod_sel = prod_p3_q;
        endcase
    end

    // ---- control FSM ----
    always_comb begin
        state_d   = state_q;
        wen_d     = 2'b00;
        data_d    = data_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mul_cnt_d = mul_cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_load  = 1'b0;
        div_kill  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.cancel && op_is_legal(bus.op)) begin
                    op_d = bus.op;
                    a_d  = bus.src_a;
                    b_d  = bus.src_b;
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = ST_MUL;
                            mul_cnt_d = 2'(MUL_PIPE);
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.src_b == '0) begin
                                // Divide by zero finishes at once, no trap.
                                state_d = ST_WB;
                                wen_d   = 2'b11;
                                data_d  = {bus.src_a, DIVZ_LO};
                            end else begin
                                state_d  = ST_DIV;
                                div_load = 1'b1;
                                qneg_d   = div_signed &
                                           (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                                rneg_d   = div_signed & bus.src_a[DATA_W-1];
                            end
                        end
                        OP_MTHI: begin
                            state_d = ST_WB;
                            wen_d   = 2'b01;
                            data_d  = {bus.src_a, {DATA_W{1'b0}}};
                        end
                        default: begin
                            state_d = ST_WB;
                            wen_d   = 2'b10;
                            data_d  = {{DATA_W{1'b0}}, bus.src_a};
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == 2'd0) begin
                    state_d = ST_WB;
                    wen_d   = 2'b11;
                    data_d  = prod_sel;
                end else begin
                    mul_cnt_d = mul_cnt_q - 2'd1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d  = ST_WB;
                    wen_d    = 2'b11;
                    data_d   = {apply_sign(div_rem, rneg_q), apply_sign(div_quot, qneg_q)};
                    div_kill = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything: nothing accepted, nothing written.
        if (bus.cancel) begin
            state_d  = ST_IDLE;
            wen_d    = 2'b00;
            data_d   = data_q;
            op_d     = op_q;
            a_d      = a_q;
            b_d      = b_q;
            div_load = 1'b0;
            div_kill = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            wen_q     <= 2'b00;
            data_q    <= '0;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            mul_cnt_q <= 2'd0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            wen_q     <= wen_d;
            data_q    <= data_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mul_cnt_q <= mul_cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign bus.busy     = busy_q;
    // A flush arriving in the write-back cycle must still block the HI/LO write.
    assign bus.wen_hiol = wen_q & {2{~bus.cancel}};
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int DATA_W   = 32;
    localparam int MUL_PIPE = 1;

    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if #(.DATA_W(DATA_W)) bus ();

    muldiv_unit #(
        .DATA_W   (DATA_W),
        .MUL_PIPE (MUL_PIPE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int          cyc    = 0;
    bit          m_pend = 1'b0;
    int          m_beat = 0;
    logic [1:0]  m_wen  = 2'b00;
    logic [63:0] m_data = '0;
    bit          chk_en = 1'b0;

    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        case (op)
            3'd0: return longint'($signed(a)) * longint'($signed(b));
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, 32'h0};
            default: return {32'h0, a};
        endcase
    endfunction

    function automatic logic [1:0] ref_wen(input logic [2:0] op);
        if (op == 3'd4) return 2'b01;
        if (op == 3'd5) return 2'b10;
        return 2'b11;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd1) return 2 + MUL_PIPE;
        if (op <= 3'd3) return (b == 32'd0) ? 1 : 34;
        return 1;
    endfunction

    function automatic bit model_busy();
        return m_pend && (cyc <= m_beat);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
        end else begin
            bit free;
            free = !m_pend || (cyc > m_beat);
            if (m_pend && cyc >= m_beat) m_pend = 1'b0;
            if (bus.cancel) begin
                m_pend = 1'b0;
            end else if (free && bus.start && bus.op <= 3'd5) begin
                m_pend = 1'b1;
                m_beat = cyc + ref_lat(bus.op, bus.src_b);
                m_wen  = ref_wen(bus.op);
                m_data = ref_result(bus.op, bus.src_a, bus.src_b);
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    logic [1:0] exp_wen;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            exp_wen = (m_pend && cyc == m_beat && !bus.cancel) ? m_wen : 2'b00;
            check("busy", 64'(bus.busy), 64'(model_busy()));
            check("wen", 64'(bus.wen_hiol), 64'(exp_wen));
            if (exp_wen != 2'b00) check("data", bus.data_out, m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start  = s;
        bus.op     = op;
        bus.src_a  = a;
        bus.src_b  = b;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while (model_busy() && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic wait_beat(input string name, input int t0, output int lat,
                             output logic [1:0] wen, output logic [63:0] data);
        bit got;
        got  = 1'b0;
        lat  = -1;
        wen  = 2'b00;
        data = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.wen_hiol != 2'b00) begin
                got  = 1'b1;
                lat  = cyc - t0;
                wen  = bus.wen_hiol;
                data = bus.data_out;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=none exp=write_beat", name);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_data,
                         input logic [1:0] exp_w, input int exp_lat);
        int t0;
        int lat;
        logic [1:0] w;
        logic [63:0] d;
        t0 = cyc;
        drive(1'b1, op, a, b);
        tick();
        bus.start = 1'b0;
        wait_beat(name, t0, lat, w, d);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_wen"}, 64'(w), 64'(exp_w));
        check({name, "_data"}, d, exp_data);
        wait_idle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int lat;
        bit seen;
        logic [1:0]  w;
        logic [63:0] d;
        int cancel_at;

        rst = 1'b1;
        bus.cancel = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_wen", 64'(bus.wen_hiol), 64'd0);
        check("reset_data", bus.data_out, 64'd0);
        tick();

        // Model pins against hand-computed values.
        check("pin_mult", ref_result(3'd0, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
        check("pin_div", ref_result(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_divu", ref_result(3'd3, 32'd7, 32'd2), 64'h0000_0001_0000_0003);
        check("pin_ovf", ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        // Directed operations with literal expectations.
        do_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2'b11, 2 + MUL_PIPE);
        do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2'b11, 2 + MUL_PIPE);
        do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 2'b11, 34);
        do_op("divu", OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 2'b11, 34);
        do_op("divu_z", OP_DIVU, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 2'b11, 1);
        do_op("div_z", OP_DIV, 32'h8000_0001, 32'd0, 64'h8000_0001_FFFF_FFFF, 2'b11, 1);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 2'b11, 34);
        do_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'd9, 64'hDEAD_BEEF_0000_0000, 2'b01, 1);
        do_op("mtlo", OP_MTLO, 32'd5, 32'd9, 64'h0000_0000_0000_0005, 2'b10, 1);

        // Illegal op code is ignored.
        drive(1'b1, 3'd6, 32'd1, 32'd1);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("op6_busy", 64'(bus.busy), 64'd0);
        tick();

        // start together with cancel: not accepted.
        drive(1'b1, OP_DIV, 32'd50, 32'd7);
        bus.cancel = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        @(negedge clk);
        check("start_cancel_busy", 64'(bus.busy), 64'd0);
        tick();

        // Cancel in the write-back cycle gates the write enables.
        drive(1'b1, OP_MTHI, 32'h1111_2222, 32'd0);
        tick();
        bus.start  = 1'b0;
        bus.cancel = 1'b1;
        @(negedge clk);
        check("wb_cancel_wen", 64'(bus.wen_hiol), 64'd0);
        tick();
        bus.cancel = 1'b0;
        @(negedge clk);
        check("wb_cancel_busy", 64'(bus.busy), 64'd0);
        tick();

        // DIV cancelled at T+10.
        t0 = cyc;
        drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        bus.start = 1'b0;
        while (cyc < t0 + 10) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wen_hiol != 2'b00) seen = 1'b1;
        end
        check("cancel_no_wen", 64'(seen), 64'd0);
        tick();

        // Second start while busy is ignored.
        t0 = cyc;
        drive(1'b1, OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        tick();
        drive(1'b1, OP_MULTU, 32'd5, 32'd7);
        tick();
        bus.start = 1'b0;
        wait_beat("busy_start", t0, lat, w, d);
        check("busy_start_lat", 64'(lat), 64'(2 + MUL_PIPE));
        check("busy_start_data", d, 64'h0000_0003_0000_0000);
        wait_idle();

        // Async reset during a division.
        drive(1'b1, OP_DIV, 32'd100, 32'd3);
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_wen", 64'(bus.wen_hiol), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_data", bus.data_out, 64'd0);
        tick();

        // Randomized traffic checked by the per-cycle compare.
        for (int n = 0; n < 250; n++) begin
            cancel_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 36)) : -1;
            drive(1'b1, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            bus.cancel = ($urandom_range(0, 15) == 0);
            tick();
            drive(1'b0, 3'($urandom), $urandom, $urandom);
            bus.cancel = 1'b0;
            for (int k = 0; k < 80; k++) begin
                if (!model_busy()) break;
                bus.start  = ($urandom_range(0, 3) == 0);
                bus.op     = 3'($urandom);
                bus.src_a  = $urandom;
                bus.src_b  = $urandom;
                bus.cancel = (k == cancel_at);
                tick();
                bus.start  = 1'b0;
                bus.cancel = 1'b0;
            end
            if (model_busy()) begin
                checks++;
                errors++;
                $display("FAIL random_timeout got=busy exp=idle");
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
